// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard for the in-order issue stage: per-register result
// countdowns drive RAW/WAW stalls, and a short counter stretches redirect kills.
module hazard_scoreboard #(
    parameter  int unsigned NREGS       = 32,
    parameter  int unsigned MAX_LAT     = 7,
    parameter  int unsigned ALU_LAT     = 3,
    parameter  int unsigned LOAD_LAT    = 5,
    parameter  int unsigned KILL_CYCLES = 2,
    localparam int unsigned RW          = $clog2(NREGS),
    localparam int unsigned CW          = $clog2(MAX_LAT + 1)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             issue_valid,
    input  logic [RW-1:0]    rs1,
    input  logic [RW-1:0]    rs2,
    input  logic             use_rs1,
    input  logic             use_rs2,
    input  logic [RW-1:0]    rd,
    input  logic             writes_rd,
    input  logic             is_load,
    input  logic             wb_valid,
    input  logic [RW-1:0]    wb_rd,
    input  logic             btaken,
    input  logic             exception,
    input  logic             discard,
    output logic             stall,
    output logic             kill,
    output logic [NREGS-1:0] busy_vec
);

    localparam int unsigned KW = $clog2(KILL_CYCLES + 1);

    logic [CW-1:0] cnt [NREGS];
    logic [KW-1:0] kcnt;
    logic [CW-1:0] lat;
    logic          raw;
    logic          waw;
    logic          kill_req;
    logic          mark;

    // Hazard detection; kill masks stall so a squashed instruction never waits.
    always_comb begin
        lat      = is_load ? CW'(LOAD_LAT) : CW'(ALU_LAT);
        raw      = (use_rs1 && (cnt[rs1] != '0)) || (use_rs2 && (cnt[rs2] != '0));
        waw      = writes_rd && (rd != '0) && (cnt[rd] > lat);
        kill_req = (btaken || exception) && !discard;
        kill     = kill_req || ((kcnt != '0) && !discard);
        stall    = issue_valid && (raw || waw) && !kill;
        mark     = issue_valid && writes_rd && (rd != '0) && !stall && !kill;
    end

    // Issue beats early release, which beats the natural countdown.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            cnt[0] <= '0;
            for (int i = 1; i < int'(NREGS); i++) begin
                if (mark && (rd == RW'(i))) begin
                    cnt[i] <= lat;
                end else if (wb_valid && (wb_rd == RW'(i))) begin
                    cnt[i] <= '0;
                end else if (cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - CW'(1);
                end
            end
        end
    end

    // A fresh request reloads the window; discard only masks, it never freezes it.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            kcnt <= '0;
        end else if (kill_req) begin
            kcnt <= KW'(KILL_CYCLES - 1);
        end else if (kcnt != '0) begin
            kcnt <= kcnt - KW'(1);
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int i = 1; i < int'(NREGS); i++) begin
            busy_vec[i] = (cnt[i] != '0);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: the driver queues the expected outputs
// of every cycle it drives and a negedge monitor pops and compares them.
module tb_hazard_scoreboard;

    logic        clk;
    logic        nrst;
    logic        issue_valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        use_rs1;
    logic        use_rs2;
    logic [4:0]  rd;
    logic        writes_rd;
    logic        is_load;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        btaken;
    logic        exception;
    logic        discard;
    logic        stall;
    logic        kill;
    logic [31:0] busy_vec;

    typedef struct {
        string       name;
        logic        stall;
        logic        kill;
        logic [31:0] busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    hazard_scoreboard dut (
        .clk         (clk),
        .nrst        (nrst),
        .issue_valid (issue_valid),
        .rs1         (rs1),
        .rs2         (rs2),
        .use_rs1     (use_rs1),
        .use_rs2     (use_rs2),
        .rd          (rd),
        .writes_rd   (writes_rd),
        .is_load     (is_load),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .btaken      (btaken),
        .exception   (exception),
        .discard     (discard),
        .stall       (stall),
        .kill        (kill),
        .busy_vec    (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every driven cycle has exactly one queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_tests++;
            if (stall !== e.stall) begin
                n_fail++;
                $display("FAIL %s stall: got %b expected %b", e.name, stall, e.stall);
            end
            n_tests++;
            if (kill !== e.kill) begin
                n_fail++;
                $display("FAIL %s kill: got %b expected %b", e.name, kill, e.kill);
            end
            n_tests++;
            if (busy_vec !== e.busy) begin
                n_fail++;
                $display("FAIL %s busy_vec: got %h expected %h", e.name, busy_vec, e.busy);
            end
        end
    end

    task automatic push_exp(input string nm, input logic es, input logic ek, input logic [31:0] eb);
        exp_t e;
        e.name  = nm;
        e.stall = es;
        e.kill  = ek;
        e.busy  = eb;
        exp_q.push_back(e);
    endtask

    // One cycle: args are iv, rs1, use1, rs2, use2, rd, wr, load, wb, wb_rd, bt, exc, disc.
    task automatic drv(input string nm,
                       input logic iv, input int r1, input logic u1, input int r2, input logic u2,
                       input int rdi, input logic wr, input logic ld,
                       input logic wb, input int wbr,
                       input logic bt, input logic ex, input logic dis,
                       input logic es, input logic ek, input logic [31:0] eb);
        @(posedge clk);
        #1;
        issue_valid = iv;
        rs1         = 5'(r1);
        use_rs1     = u1;
        rs2         = 5'(r2);
        use_rs2     = u2;
        rd          = 5'(rdi);
        writes_rd   = wr;
        is_load     = ld;
        wb_valid    = wb;
        wb_rd       = 5'(wbr);
        btaken      = bt;
        exception   = ex;
        discard     = dis;
        push_exp(nm, es, ek, eb);
    endtask

    task automatic idle(input string nm, input logic ek, input logic [31:0] eb);
        drv(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ek, eb);
    endtask

    // Holds reset over one full cycle with btaken high: kill must still follow the request.
    task automatic reset_cycle(input string nm, input logic bt);
        @(posedge clk);
        #1;
        nrst = 1'b0;
        issue_valid = 0; use_rs1 = 0; use_rs2 = 0; writes_rd = 0; is_load = 0;
        wb_valid = 0; exception = 0; discard = 0; btaken = bt;
        push_exp(nm, 1'b0, bt, 32'h0);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        btaken = 1'b0;
    endtask

    initial begin
        nrst = 1'b0;
        issue_valid = 0; rs1 = 0; rs2 = 0; use_rs1 = 0; use_rs2 = 0; rd = 0;
        writes_rd = 0; is_load = 0; wb_valid = 0; wb_rd = 0;
        btaken = 0; exception = 0; discard = 0;
        repeat (2) @(posedge clk);
        reset_cycle("rst_init", 1'b0);

        // RAW: ALU rd=5, dependent on rs1=5 stalls three cycles.
        drv("raw_issue", 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        drv("raw_t1",    1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h20);
        drv("raw_t2",    1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h20);
        drv("raw_t3",    1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h20);
        drv("raw_t4",    1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);

        // WAW: load rd=7 then ALU rd=7 waits while cnt[7] > 3.
        drv("waw_load",  1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        drv("waw_t1",    1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 1, 0, 32'h80);
        drv("waw_t2",    1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 1, 0, 32'h80);
        drv("waw_t3",    1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h80);
        idle("waw_t4", 0, 32'h80);
        idle("waw_t5", 0, 32'h80);
        idle("waw_t6", 0, 32'h80);
        idle("waw_t7", 0, 32'h0);

        // Early release via wb_valid, then issue beating a same-cycle release.
        drv("wb_load",   1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        idle("wb_t1", 0, 32'h200);
        drv("wb_rel",    0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 32'h200);
        drv("wb_dep",    1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        drv("wb_race",   1, 0, 0, 0, 0, 10, 1, 0, 1, 10, 0, 0, 0, 0, 0, 32'h0);
        idle("wb_race1", 0, 32'h400);
        idle("wb_race2", 0, 32'h400);
        idle("wb_race3", 0, 32'h400);
        idle("wb_race4", 0, 32'h0);

        // Kill window overrides a pending RAW, is extended by a second btaken, marks nothing.
        drv("kill_pre",  1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        drv("kill_bt1",  1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 1, 0, 0, 0, 1, 32'h8);
        drv("kill_bt2",  1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 1, 0, 0, 0, 1, 32'h8);
        drv("kill_tail", 1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8);
        idle("kill_end", 0, 32'h0);

        // Discard: masks requests and window cycles, window still counts down.
        drv("dis_req",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 32'h0);
        idle("dis_noload", 0, 32'h0);
        drv("dis_exc",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h0);
        drv("dis_mask",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0);
        idle("dis_spent", 0, 32'h0);
        drv("dis_exc2",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h0);
        idle("dis_drop", 1, 32'h0);
        idle("dis_done", 0, 32'h0);

        // Register 0 and reset with three registers busy.
        drv("r0_write",  1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        drv("r0_use",    1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        drv("rst_rd1",   1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        drv("rst_rd2",   1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h2);
        drv("rst_rd3",   1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h6);
        idle("rst_busy", 0, 32'hE);
        reset_cycle("rst_mid", 1'b1);
        drv("rst_after", 1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        idle("rst_quiet", 0, 32'h0);

        repeat (4) @(posedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
